mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001: Parameter DEPTH_WORDS, 256, number of 32-bit words stored; power of two, 2 to 65536.
- REQ-002: Parameter LATENCY, 2, cycles from request accept to rsp_valid; 1 to 15.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset; synchronous, active-high.
- REQ-005: req_valid  input  1  initiator presents a request.
- REQ-006: req_ready  output  1  responder can accept a request this cycle.
- REQ-007: req_we  input  1  1 = store, 0 = load.
- REQ-008: req_addr  input  32  byte address.
- REQ-009: req_wdata  input  32  store data.
- REQ-010: req_wstrb  input  4  store byte enables; bit i selects byte lane i (little-endian).
- REQ-011: rsp_valid  output  1  response available.
- REQ-012: rsp_ready  input  1  initiator consumes the response.
- REQ-013: rsp_rdata  output  32  load data; 0 for stores.
- REQ-014: rsp_err  output  1  request faulted.

Function
- REQ-015: The FSM SHALL have states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
- REQ-016: A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_* is sampled only at that edge.
- REQ-017: On accept, a non-faulting store SHALL write each byte lane whose req_wstrb bit is 1 at word index req_addr[AW+1:2], AW = log2(DEPTH_WORDS); unselected lanes are unchanged.
- REQ-018: On accept, the FSM SHALL go to RESP if LATENCY = 1, otherwise to WAIT with the counter loaded to LATENCY-1.
- REQ-019: In WAIT, the counter SHALL decrement each cycle; the FSM moves to RESP on the edge where the counter equals 1.
- REQ-020: rsp_valid SHALL be 1 exactly LATENCY cycles after the accepting edge and only in RESP.
- REQ-021: On entry to RESP, rsp_rdata SHALL latch the addressed word for loads and 0 for stores; rsp_err SHALL latch the fault flag.
- REQ-022: rsp_rdata and rsp_err SHALL be held stable while rsp_valid = 1 and rsp_ready = 0.
- REQ-023: On an edge with rsp_valid = 1 and rsp_ready = 1, the FSM SHALL return to IDLE; req_ready is 1 in the next cycle; at most one request is outstanding.
- REQ-024: A load to the address of the previous store SHALL return the stored data.

Reset
- REQ-025: On an edge with rst = 1, state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 in the following cycle.
- REQ-026: Reset mid-transaction SHALL discard the pending response without a rsp_valid pulse; a store accepted before reset remains committed.
- REQ-027: Reset SHALL NOT clear memory contents.

Configuration
- REQ-028: With MEM_RESPONDER_ERR_EN defined, a request faults if req_addr[1:0] != 0 or req_addr >= 4*DEPTH_WORDS; a faulting store writes nothing and a faulting load returns rsp_rdata = 0 with rsp_err = 1.
- REQ-029: Without MEM_RESPONDER_ERR_EN, rsp_err SHALL be constant 0, req_addr[1:0] is ignored, and the word index wraps modulo DEPTH_WORDS.

Structure
- REQ-030: Package mem_responder_pkg SHALL hold the state enumeration (IDLE, WAIT, RESP) and the byte-lane count constant (4).
- REQ-031: Sub-module mem_responder_ram SHALL hold the DEPTH_WORDS x 32 byte-lane-enabled array with a synchronous write port and an asynchronous read port; the FSM, counter and error check stay in mem_responder.

Verification
- REQ-032: Store 0xDEADBEEF to 0x10 with wstrb 0xF, then load 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, and rsp_valid rises exactly LATENCY cycles after each accept.
- REQ-033: Store 0x000000AA to 0x10 with wstrb 0x1 over 0xDEADBEEF, then load -> 0xDEADBEAA.
- REQ-034: Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant, req_ready = 0, and a concurrent req_valid is not accepted.
- REQ-035: With MEM_RESPONDER_ERR_EN defined, load 0x12 and store to 4*DEPTH_WORDS -> rsp_err = 1, rsp_rdata = 0, and memory is unchanged; without the macro, load 4*DEPTH_WORDS+0x10 -> returns the word at 0x10 with rsp_err = 0.
- REQ-036: Assert rst one cycle after accepting a load -> no rsp_valid pulse, and the next cycle shows req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
- REQ-037: Run LATENCY = 1 and LATENCY = 15 builds with back-to-back requests and rsp_ready tied 1 -> one response per LATENCY+1 cycles, with data matching a reference model.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LANES = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// DEPTH_WORDS x 32 storage: byte-lane-enabled synchronous write, asynchronous read.
module mem_responder_ram
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [LANES-1:0]     wstrb,
   input  logic [AW-1:0]        waddr,
   input  logic [8*LANES-1:0]   wdata,
   input  logic [AW-1:0]        raddr,
   output logic [8*LANES-1:0]   rdata
);

   logic [8*LANES-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Optional feature: define MEM_RESPONDER_ERR_EN to fault misaligned / out-of-range requests.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic          accept, fault, enter_resp;
   logic [AW-1:0] req_idx, rd_idx;
   logic [AW-1:0] addr_p0;
   logic          we_p0, fault_p0;
   logic          src_we, src_fault;
   logic [31:0]   ram_rdata;
   logic [31:0]   rdata_r;
   logic          err_r;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;
   assign req_idx   = req_addr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
   assign fault = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
   logic unused_addr_bits;
   assign fault            = 1'b0;
   assign unused_addr_bits = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};
`endif

   // Stores commit at the accepting edge; a later reset cannot undo them.
   mem_responder_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_ram (
      .clk  (clk),
      .we   (accept & req_we & ~fault & ~rst),
      .wstrb(req_wstrb),
      .waddr(req_idx),
      .wdata(req_wdata),
      .raddr(rd_idx),
      .rdata(ram_rdata)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
                  cnt_n   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) state_n = RESP;
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // With LATENCY = 1 RESP is entered on the accepting edge, so read the live request.
   assign enter_resp = (state_n == RESP) && (state != RESP);
   assign rd_idx     = (state == IDLE) ? req_idx : addr_p0;
   assign src_we     = (state == IDLE) ? req_we  : we_p0;
   assign src_fault  = (state == IDLE) ? fault   : fault_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (enter_resp) begin
            rdata_r <= (src_we | src_fault) ? 32'd0 : ram_rdata;
            err_r   <= src_fault;
         end
      end
   end

   // Stage p0: request fields captured at accept, held until the response is formed.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0  <= req_idx;
         we_p0    <= req_we;
         fault_p0 <= fault;
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_r;
   assign rsp_err   = err_r;

endmodule
